// File: rtl/mac_tx_packer_if.sv
// mac_tx_packer_if: byte-stream input and MAC Tx word output handshake bundle
// Signals:
//   in_valid/in_ready/in_data/in_last   byte stream into the packer
//   tx_mac_wa                           MAC write-allowed
//   tx_mac_wr/data/be/sop/eop           packed word stream towards the MAC
// Modports: master = stream source / MAC side, slave = packer side.
interface mac_tx_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        tx_mac_wa;
    logic        tx_mac_wr;
    logic [31:0] tx_mac_data;
    logic [1:0]  tx_mac_be;
    logic        tx_mac_sop;
    logic        tx_mac_eop;
    modport master (
        output in_valid, in_data, in_last, tx_mac_wa,
        input  in_ready, tx_mac_wr, tx_mac_data, tx_mac_be, tx_mac_sop, tx_mac_eop
    );
    modport slave (
        input  in_valid, in_data, in_last, tx_mac_wa,
        output in_ready, tx_mac_wr, tx_mac_data, tx_mac_be, tx_mac_sop, tx_mac_eop
    );
endinterface

// File: rtl/mac_tx_packer.sv
// mac_tx_packer: packs a byte stream big-endian into 32-bit MAC Tx words through a word FIFO
// Ports:
//   clk_user     user clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   bus          mac_tx_packer_if.slave: in_* byte stream in, tx_mac_* words out
//   o_frame_cnt  frames fully written to the MAC (wraps)
//   o_byte_cnt   bytes written to the MAC, padding included (wraps)
//   o_trunc_err  sticky: a frame exceeded MAX_LEN
// Build option: define MAC_TX_PAD_EN to zero-pad frames shorter than MIN_LEN.
module mac_tx_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LEN    = 1518,
    parameter int MIN_LEN    = 60
) (
    input  logic           clk_user,
    input  logic           reset,
    mac_tx_packer_if.slave bus,
    output logic [15:0]    o_frame_cnt,
    output logic [31:0]    o_byte_cnt,
    output logic           o_trunc_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] MAX_C   = LW'(MAX_LEN);
    localparam logic [LW-1:0] SAT_C   = LW'(MAX_LEN + 1);
    localparam logic [LW-1:0] MIN_C   = LW'(MIN_LEN);
`ifdef MAC_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_lane;
    logic [31:0]   r_word;
    logic [LW-1:0] r_len;
    logic          r_first;
    logic [35:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [15:0]   r_frame_cnt;
    logic [31:0]   r_byte_cnt;
    logic          r_trunc;

    logic          w_rd;
    logic          w_free;
    logic          w_ready;
    logic          w_acc;
    logic          w_pad;
    logic [LW-1:0] w_len_nx;
    logic          w_short;
    logic          w_store;
    logic          w_adv;
    logic [31:0]   w_word;
    logic          w_end;
    logic          w_commit;
    logic [1:0]    w_be;
    logic [35:0]   w_head;

    always_ff @(posedge clk_user) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Short frames divert into PAD instead of closing; PAD closes once MIN_LEN is reached.
    always_comb begin
        w_next = (r_state == S_PAD)        ? (w_end ? S_IDLE : S_PAD)
               : (w_acc && bus.in_last)    ? (w_short ? S_PAD : S_IDLE)
               : w_acc                     ? S_FILL
               :                             r_state;
    end

    // A free entry exists if the FIFO is not full or the head leaves this cycle.
    // Bytes beyond MAX_LEN are accepted but not stored; len saturates at MAX_LEN+1.
    always_comb begin
        w_rd     = (r_cnt != '0) && bus.tx_mac_wa;
        w_free   = (r_cnt < DEPTH_C) || w_rd;
        w_ready  = (r_state != S_PAD) && w_free;
        w_acc    = bus.in_valid && w_ready;
        w_pad    = (r_state == S_PAD) && w_free;
        w_len_nx = (r_state == S_IDLE) ? LW'(1) : (r_len == SAT_C) ? r_len : r_len + 1'b1;
        w_short  = PAD_EN && (w_len_nx < MIN_C);
        w_store  = w_acc && (w_len_nx <= MAX_C);
        w_adv    = w_store || w_pad;
        w_word   = w_adv ? (r_word | ({w_pad ? 8'h00 : bus.in_data, 24'h0} >> {r_lane, 3'b000})) : r_word;
        w_end    = w_pad ? (w_len_nx == MIN_C) : (w_acc && bus.in_last && !w_short);
        w_commit = w_end || (w_adv && r_lane == 2'd3);
        // A truncated frame closes on a dropped byte, so its residue is r_lane bytes.
        w_be     = w_end ? (w_adv ? r_lane + 2'd1 : r_lane) : 2'b00;
    end

    always_ff @(posedge clk_user) begin
        if (w_commit) r_mem[r_wp] <= {r_first, w_end, w_be, w_word};
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_lane      <= 2'd0;
            r_word      <= '0;
            r_len       <= '0;
            r_first     <= 1'b1;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            r_byte_cnt  <= '0;
            r_trunc     <= 1'b0;
        end else begin
            if (w_acc || w_pad) r_len <= w_len_nx;
            if (w_acc && !w_store) r_trunc <= 1'b1;
            if (w_commit) begin
                r_word  <= '0;
                r_lane  <= 2'd0;
                r_first <= w_end;
                r_wp    <= r_wp + 1'b1;
            end else if (w_adv) begin
                r_word <= w_word;
                r_lane <= r_lane + 2'd1;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_commit} - {{AW{1'b0}}, w_rd};
            if (w_rd) begin
                r_rp        <= r_rp + 1'b1;
                r_frame_cnt <= r_frame_cnt + {15'd0, w_head[34]};
                r_byte_cnt  <= r_byte_cnt + ((w_head[34] && w_head[33:32] != 2'b00) ? {30'd0, w_head[33:32]} : 32'd4);
            end
        end
    end

    assign w_head          = r_mem[r_rp];
    assign bus.in_ready    = w_ready;
    assign bus.tx_mac_wr   = w_rd;
    assign bus.tx_mac_data = w_rd ? w_head[31:0] : 32'h0;
    assign bus.tx_mac_be   = w_rd ? w_head[33:32] : 2'b00;
    assign bus.tx_mac_eop  = w_rd && w_head[34];
    assign bus.tx_mac_sop  = w_rd && w_head[35];
    assign o_frame_cnt     = r_frame_cnt;
    assign o_byte_cnt      = r_byte_cnt;
    assign o_trunc_err     = r_trunc;
endmodule
